// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field layout and the
// fetch/decode FSM state encoding. The eu and ALU import the same constants.
package cpu_pkg;

    localparam logic [3:0] OP_ALU_MAX = 4'hC;
    localparam logic [3:0] OP_BRZ     = 4'hD;
    localparam logic [3:0] OP_JMP     = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    // Field LSB positions inside the instruction word; bits above 26 are ignored.
    localparam int OPC_LSB   = 23;
    localparam int A1_LSB    = 18;
    localparam int A2_LSB    = 13;
    localparam int A3_LSB    = 8;
    localparam int NUM_LSB   = 0;
    localparam int INSTR_MSB = 26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_DECODE,
        S_ISSUE,
        S_HALTED
    } fd_state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [4:0] addr1;
        logic [4:0] addr2;
        logic [4:0] addr3;
        logic [7:0] number;
    } instr_fields_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_ALU_MAX;
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Instruction ROM port plus the decoded-issue handshake toward the eu.
interface fetch_decode_if #(
    parameter int PC_W = 8,
    parameter int IW   = 32
);
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_data;
    logic [3:0]      opcode;
    logic [4:0]      addr1;
    logic [4:0]      addr2;
    logic [4:0]      addr3;
    logic [7:0]      number;
    logic            issue_valid;
    logic            eu_ready;
    logic [3:0]      eu_flag;

    modport master (
        output imem_addr, opcode, addr1, addr2, addr3, number, issue_valid,
        input  imem_data, eu_ready, eu_flag
    );

    modport slave (
        input  imem_addr, opcode, addr1, addr2, addr3, number, issue_valid,
        output imem_data, eu_ready, eu_flag
    );
endinterface

// File: rtl/fetch_decode_instr_decode.sv
// Combinational field slicing and opcode classification of a held instruction.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_MSB:0] instr,
    output instr_fields_t      fields,
    output logic               is_alu,
    output logic               is_brz,
    output logic               is_jmp,
    output logic               is_halt
);

    always_comb begin
        fields.opcode = instr[OPC_LSB +: 4];
        fields.addr1  = instr[A1_LSB  +: 5];
        fields.addr2  = instr[A2_LSB  +: 5];
        fields.addr3  = instr[A3_LSB  +: 5];
        fields.number = instr[NUM_LSB +: 8];
    end

    assign is_alu  = is_alu_op(fields.opcode);
    assign is_brz  = (fields.opcode == OP_BRZ);
    assign is_jmp  = (fields.opcode == OP_JMP);
    assign is_halt = (fields.opcode == OP_HALT);

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: owns the PC, reads the sync ROM, resolves JMP/BRZ/HALT
// locally and issues ALU ops to the eu over a valid/ready handshake.
module fetch_decode
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              IW       = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    fetch_decode_if.master    bus,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    fd_state_e           state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_MSB:0]  ir_q, ir_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;

    instr_fields_t       fields;
    logic                is_alu, is_brz, is_jmp, is_halt;
    logic [PC_W-1:0]     pc_inc, target;

    instr_decode u_dec (
        .instr   (ir_q),
        .fields  (fields),
        .is_alu  (is_alu),
        .is_brz  (is_brz),
        .is_jmp  (is_jmp),
        .is_halt (is_halt)
    );

    assign pc_inc = pc_q + PC_W'(1);
    assign target = PC_W'(fields.number);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                ir_d    = bus.imem_data[INSTR_MSB:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu) begin
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end else if (is_jmp) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (is_brz) begin
                    // Hold until the eu is idle so the zero flag reflects the prior op.
                    if (bus.eu_ready) begin
                        pc_d    = bus.eu_flag[0] ? target : pc_inc;
                        state_d = S_FETCH;
                    end
                end else if (is_halt) begin
                    halted_d = 1'b1;
                    state_d  = S_HALTED;
                end
            end
            S_ISSUE: begin
                if (bus.eu_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.opcode      = fields.opcode;
    assign bus.addr1       = fields.addr1;
    assign bus.addr2       = fields.addr2;
    assign bus.addr3       = fields.addr3;
    assign bus.number      = fields.number;
    assign bus.issue_valid = valid_q;
    assign pc              = pc_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: program in a behavioural sync ROM, expected
// values hand-computed from the instruction encodings below.
module tb_fetch_decode;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  pc;
    logic        halted;
    logic [31:0] rom [0:255];
    int          total = 0;
    int          bad   = 0;

    fetch_decode_if #(.PC_W(8), .IW(32)) bus ();

    fetch_decode #(.PC_W(8), .IW(32), .RESET_PC(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    function automatic logic [31:0] enc(input logic [4:0] hi, input logic [3:0] op,
                                        input logic [4:0] a1, input logic [4:0] a2,
                                        input logic [4:0] a3, input logic [7:0] n);
        return {hi, op, a1, a2, a3, n};
    endfunction

    function automatic logic [26:0] flds();
        return {bus.opcode, bus.addr1, bus.addr2, bus.addr3, bus.number};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bus.eu_ready = 1'b0; bus.eu_flag = 4'h0;
        tick(); tick();
        reset = 1'b0;
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", pc); end
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL reset_imem_addr got=%h exp=00", bus.imem_addr); end
        total++; if (bus.issue_valid !== 1'b0 || halted !== 1'b0) begin bad++;
            $display("FAIL reset_flags valid=%b halted=%b exp=0/0", bus.issue_valid, halted); end
        total++; if (flds() !== 27'h0) begin bad++; $display("FAIL reset_fields got=%h exp=0", flds()); end
        tick(); tick(); tick();
        total++; if (pc !== 8'h00 || bus.issue_valid !== 1'b0) begin bad++;
            $display("FAIL idle_hold pc=%h valid=%b exp=00/0", pc, bus.issue_valid); end
    endtask

    task automatic test_alu();
        logic [26:0] exp_f;
        exp_f = {4'h3, 5'd1, 5'd2, 5'd3, 8'h55};
        bus.eu_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            total++; if (bus.issue_valid !== 1'b0) begin bad++;
                $display("FAIL alu_early_valid cycle=%0d got=%b exp=0", i, bus.issue_valid); end
            tick();
        end
        total++; if (bus.issue_valid !== 1'b1) begin bad++; $display("FAIL alu_valid_c4 got=%b exp=1", bus.issue_valid); end
        total++; if (flds() !== exp_f) begin bad++; $display("FAIL alu_fields got=%h exp=%h", flds(), exp_f); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL alu_pc_before got=%h exp=00", pc); end
        tick();
        total++; if (bus.issue_valid !== 1'b0 || pc !== 8'h01) begin bad++;
            $display("FAIL alu_transfer valid=%b pc=%h exp=0/01", bus.issue_valid, pc); end
    endtask

    task automatic test_jmp();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.issue_valid !== 1'b0) begin bad++;
                $display("FAIL jmp_no_issue cycle=%0d got=%b exp=0", i, bus.issue_valid); end
        end
        total++; if (pc !== 8'h10 || bus.imem_addr !== 8'h10) begin bad++;
            $display("FAIL jmp_target pc=%h addr=%h exp=10/10", pc, bus.imem_addr); end
    endtask

    task automatic test_stall();
        logic [26:0] exp_f;
        exp_f = {4'hC, 5'd31, 5'd0, 5'd17, 8'hA5};
        bus.eu_ready = 1'b0;
        tick(); tick(); tick();
        total++; if (bus.issue_valid !== 1'b1 || flds() !== exp_f) begin bad++;
            $display("FAIL stall_issue valid=%b fields=%h exp=1/%h", bus.issue_valid, flds(), exp_f); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.issue_valid !== 1'b1 || flds() !== exp_f || pc !== 8'h10) begin bad++;
                $display("FAIL stall_hold cycle=%0d valid=%b fields=%h pc=%h exp=1/%h/10",
                         i, bus.issue_valid, flds(), pc, exp_f); end
        end
        bus.eu_ready = 1'b1;
        tick();
        total++; if (bus.issue_valid !== 1'b0 || pc !== 8'h11) begin bad++;
            $display("FAIL stall_transfer valid=%b pc=%h exp=0/11", bus.issue_valid, pc); end
    endtask

    task automatic test_brz();
        bus.eu_flag = 4'b0001;
        tick(); tick();
        total++; if (pc !== 8'h11) begin bad++; $display("FAIL brz_decode_pc got=%h exp=11", pc); end
        tick();
        total++; if (pc !== 8'h20 || bus.issue_valid !== 1'b0) begin bad++;
            $display("FAIL brz_taken pc=%h valid=%b exp=20/0", pc, bus.issue_valid); end
        bus.eu_flag = 4'b0000;
        tick(); tick(); tick();
        total++; if (pc !== 8'h21) begin bad++; $display("FAIL brz_not_taken got=%h exp=21", pc); end
        bus.eu_flag = 4'b0001; bus.eu_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc !== 8'h21 || bus.issue_valid !== 1'b0) begin bad++;
                $display("FAIL brz_wait cycle=%0d pc=%h valid=%b exp=21/0", i, pc, bus.issue_valid); end
        end
        bus.eu_ready = 1'b1;
        tick();
        total++; if (pc !== 8'h30) begin bad++; $display("FAIL brz_wait_resolve got=%h exp=30", pc); end
    endtask

    task automatic test_wrap();
        tick(); tick(); tick();
        total++; if (pc !== 8'hFF) begin bad++; $display("FAIL wrap_jmp got=%h exp=ff", pc); end
        tick(); tick(); tick();
        total++; if (bus.issue_valid !== 1'b1 || bus.opcode !== 4'h0 || bus.number !== 8'h01) begin bad++;
            $display("FAIL wrap_issue valid=%b op=%h num=%h exp=1/0/01", bus.issue_valid, bus.opcode, bus.number); end
        tick();
        total++; if (pc !== 8'h00 || bus.issue_valid !== 1'b0) begin bad++;
            $display("FAIL wrap_pc pc=%h valid=%b exp=00/0", pc, bus.issue_valid); end
    endtask

    task automatic test_halt();
        rom[0] = enc(5'h0, OP_HALT, 5'd0, 5'd0, 5'd0, 8'h00);
        reset = 1'b1; tick(); reset = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", halted); end
        tick();
        total++; if (halted !== 1'b1 || bus.issue_valid !== 1'b0) begin bad++;
            $display("FAIL halt_set halted=%b valid=%b exp=1/0", halted, bus.issue_valid); end
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (halted !== 1'b1 || pc !== 8'h00 || bus.issue_valid !== 1'b0) begin bad++;
                $display("FAIL halt_hold cycle=%0d halted=%b pc=%h valid=%b exp=1/00/0",
                         i, halted, pc, bus.issue_valid); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        rom[0] = enc(5'h0, OP_JMP, 5'd0, 5'd0, 5'd0, 8'h40);
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_from_halt got=%b exp=0", halted); end
        bus.eu_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++; if (bus.issue_valid !== 1'b1 || pc !== 8'h40) begin bad++;
            $display("FAIL mid_issue_setup valid=%b pc=%h exp=1/40", bus.issue_valid, pc); end
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if (bus.issue_valid !== 1'b0 || pc !== 8'h00 || halted !== 1'b0 || flds() !== 27'h0) begin bad++;
            $display("FAIL mid_issue_reset valid=%b pc=%h halted=%b fields=%h exp=0/00/0/0",
                     bus.issue_valid, pc, halted, flds()); end
        bus.eu_ready = 1'b1;
        tick(); tick(); tick(); tick();
        total++; if (bus.issue_valid !== 1'b0 || pc !== 8'h00) begin bad++;
            $display("FAIL post_reset_idle valid=%b pc=%h exp=0/00", bus.issue_valid, pc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        rom[8'h00] = enc(5'h00, 4'h3, 5'd1,  5'd2, 5'd3,  8'h55);
        rom[8'h01] = enc(5'h00, OP_JMP, 5'd0, 5'd0, 5'd0, 8'h10);
        rom[8'h10] = enc(5'h15, 4'hC, 5'd31, 5'd0, 5'd17, 8'hA5);
        rom[8'h11] = enc(5'h00, OP_BRZ, 5'd0, 5'd0, 5'd0, 8'h20);
        rom[8'h20] = enc(5'h00, OP_BRZ, 5'd0, 5'd0, 5'd0, 8'h40);
        rom[8'h21] = enc(5'h00, OP_BRZ, 5'd0, 5'd0, 5'd0, 8'h30);
        rom[8'h30] = enc(5'h00, OP_JMP, 5'd0, 5'd0, 5'd0, 8'hFF);
        rom[8'h40] = enc(5'h00, 4'h7, 5'd4, 5'd5, 5'd6, 8'h99);
        rom[8'hFF] = enc(5'h00, 4'h0, 5'd0, 5'd0, 5'd0, 8'h01);

        test_reset();
        test_alu();
        test_jmp();
        test_stall();
        test_brz();
        test_wrap();
        test_halt();
        test_reset_mid_issue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
